// File: rtl/pipe_stage_reg.sv
// Configurable-width pipeline stage register: valid/ready handshake, flush, saturating stall counter.
// Build option: define PIPE_STAGE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] NOP_VAL   = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nxt_s;
  logic             out_valid_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             in_ready_r;

  // Ready register: low exactly while the skid entry is occupied
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r <= 1'b1;
    end else begin
      in_ready_r <= (state_nxt_s != ST_FULL);
    end
  end

  // Skid entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_r <= RESET_VAL;
    end else begin
      skid_r <= skid_nxt_s;
    end
  end

  assign in_ready_s = in_ready_r;
`else
  // Legacy stall-register behaviour: accept whenever the held payload leaves or there is none
  assign in_ready_s = !rst && (out_ready || !out_valid_r);
`endif

  assign in_xfer_s  = in_valid & in_ready_s;
  assign out_xfer_s = out_valid_r & out_ready;

  // Next-state and next-payload selection; flush overrides the handshake
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
`ifdef PIPE_STAGE_SKID_EN
    skid_nxt_s  = skid_r;
`endif
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_nxt_s  = NOP_VAL;
`ifdef PIPE_STAGE_SKID_EN
      skid_nxt_s  = NOP_VAL;
`endif
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
          end else if (out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else if (in_xfer_s) begin
`ifdef PIPE_STAGE_SKID_EN
            skid_nxt_s  = in_data;
            state_nxt_s = ST_FULL;
`else
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
`endif
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (out_ready) begin
            main_nxt_s  = skid_r;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
`endif
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Main entry, state and output-valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_r      <= RESET_VAL;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Saturating stall counter; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the pipelined MIPS core. It generalises the fixed 64-bit stall-only stage register into a configurable-width stage with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. A saturating stall counter is included. It is instantiated between any two pipeline stages, for example IF/ID or ID/EX, with the payload packed into `in_data`.

## Interface
- `WIDTH`, 64: payload width in bits (e.g. `{pcPlus4, instr}`).
- `RESET_VAL`, 0: value of `out_data` after reset.
- `NOP_VAL`, 0: value loaded into `out_data` on flush (bubble payload).
- `CNT_W`, 16: width of the stall counter.
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `flush`  in  1: synchronous kill of all held entries.
- `in_valid`  in  1: upstream has a payload.
- `in_ready`  out  1: stage can accept; a transfer occurs when `in_valid & in_ready`.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: `out_data` holds a live payload.
- `out_ready`  in  1: downstream accepts; a transfer occurs when `out_valid & out_ready`.
- `out_data`  out  WIDTH: payload to downstream.
- `stall_cnt`  out  CNT_W: cycles with `out_valid & !out_ready`, saturating.

## Operation
- Storage: main entry (drives `out_*`) and skid entry (skid entry present only with `PIPE_STAGE_SKID_EN`).
- States: EMPTY (`out_valid`=0), ONE (main valid, skid empty), FULL (both valid).
- `in_ready` is registered and equals "skid empty". It is 1 in EMPTY and ONE, and 0 in FULL.
- EMPTY: on an input transfer, main <= `in_data` and the state goes to ONE. Otherwise the state holds.
- ONE, with both an input transfer and an output transfer: main <= `in_data`, state stays ONE.
- ONE, output transfer only: the state goes to EMPTY and `out_data` holds its last value.
- ONE, input transfer only: skid <= `in_data`, state goes to FULL.
- ONE, neither transfer: the state holds.
- FULL, on `out_ready`: main <= skid, state goes to ONE. Otherwise the state holds.
- FULL: `in_valid` is ignored.
- Priority is `rst` > `flush` > handshake.
- Flush: next state is EMPTY, `out_data` <= `NOP_VAL`, and the skid is cleared. Any input or output transfer in the flush cycle is discarded, i.e. the downstream must not consume it.
- Reset values: `out_valid`=0, `out_data`=`RESET_VAL`, `in_ready`=1, `stall_cnt`=0, skid invalid.
  - Transfers presented while `rst`=1 are discarded.
  - Reset mid-FULL drops both entries.
- `stall_cnt` increments on each `out_valid & !out_ready` cycle and saturates at 2^CNT_W-1 without wrapping. Only `rst` clears it; `flush` does not.
- Ordering is strictly FIFO: no payload is duplicated, lost (except by flush or rst) or reordered.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`/`out_data`. Throughput is 1 transfer per cycle in steady state.
- `out_data` and `out_valid` are stable while `out_valid & !out_ready`.
- With the skid buffer there is no combinational path from any input to any output. `in_ready` deasserts the cycle after the stage enters FULL.
- Without the skid buffer, `in_ready` depends combinationally on `out_ready`, with no other comb path.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid behaviour as above, with fully registered `in_ready`.
- `PIPE_STAGE_SKID_EN` undefined: single entry with no FULL state.
  - `in_ready = out_ready | !out_valid` (combinational), including during flush.
  - `in_ready` is forced to 0 while `rst`=1.
  - Main is loaded on every input transfer.
  - This is equivalent to the legacy stall register with `stall = !out_ready`.

## Test plan
- Reset/flush values: hold `rst` for 2 cycles with `RESET_VAL`=0x1234 -> `out_valid`=0, `out_data`=0x1234, `in_ready`=1 (skid build), `stall_cnt`=0. After fill and `flush`=1 with `NOP_VAL`=0 -> `out_valid`=0 and `out_data`=0 next cycle.
- Streaming: `in_valid`=1 with data 1,2,3,4 on consecutive cycles, `out_ready`=1 -> `out_data` 1,2,3,4 one cycle later, back-to-back, with `in_ready` held at 1.
- Backpressure (skid): send A then B with `out_ready`=0 -> state FULL and `in_ready`=0 from the cycle after B. Hold for 5 cycles, then `out_ready`=1 -> A then B with no loss, and `stall_cnt` counts the stalled cycles.
- Flush with transfers: in FULL, assert `flush`, `in_valid` and `out_ready` in the same cycle -> EMPTY next cycle, the offered payload is dropped, and no output transfer is counted.
- Saturation: `CNT_W`=4 with 20 stall cycles -> `stall_cnt`=15 and it stays at 15.
- Non-skid build: `out_ready`=0 while `out_valid`=1 -> `in_ready`=0 in the same cycle. Raise `out_ready` -> `in_ready`=1 in the same cycle and the next payload loads on that edge.
